// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Two-requester arbiter and sequencer for one shared 32-bit memory port.
// Requester 0 is instruction fetch, requester 1 is data load/store.
// The winner's address, write data and write enable are latched, and one
// memory transaction is run to completion or until TIMEOUT BUSY cycles pass.
// Optional build macro ARB_FIXED_PRIO_EN: requester 1 always wins a tie and
// the last-owner flop is not built. Without it, ties alternate round-robin.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    input  logic          we0,
    input  logic          we1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          done0,
    output logic          done1,
    output logic          err,
    output logic [DW-1:0] rdata,
    output logic          mux_s,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic          mem_ready,
    input  logic [DW-1:0] mem_rdata
);

    // The counter holds 0 .. TIMEOUT-1 (one value per BUSY cycle).
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [CW-1:0]   cnt_r;
    logic            any_req_s;
    logic            pick1_s;
    logic            timeout_s;

    assign any_req_s = req0 | req1;
    assign timeout_s = (cnt_r == CW'(TIMEOUT - 1));

`ifdef ARB_FIXED_PRIO_EN
    // Fixed priority: data (requester 1) wins whenever it is requesting.
    always_comb begin
        pick1_s = req1;
    end
`else
    logic last_owner_r;

    // Round-robin: on a tie the requester that was not granted last wins.
    always_comb begin
        pick1_s = 1'b0;
        if (req0 && req1) begin
            pick1_s = ~last_owner_r;
        end else begin
            pick1_s = req1;
        end
    end

    // Remember who owned the port last; resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner_r <= 1'b1;
        end else if (state_r == ST_IDLE && any_req_s) begin
            last_owner_r <= pick1_s;
        end else begin
            last_owner_r <= last_owner_r;
        end
    end
`endif

    // Next-state logic: IDLE -> BUSY on a request, BUSY -> DONE on ready or timeout.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_s = ST_BUSY;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (mem_ready || timeout_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_BUSY;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Registered outputs: grant/latch in IDLE, complete or time out in BUSY, pulse done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            err       <= 1'b0;
            rdata     <= {DW{1'b0}};
            mux_s     <= 1'b0;
            mem_req   <= 1'b0;
            mem_addr  <= {AW{1'b0}};
            mem_wdata <= {DW{1'b0}};
            mem_we    <= 1'b0;
            cnt_r     <= {CW{1'b0}};
        end else begin
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (any_req_s) begin
                        gnt0      <= ~pick1_s;
                        gnt1      <= pick1_s;
                        mux_s     <= ~pick1_s;
                        mem_addr  <= pick1_s ? addr1  : addr0;
                        mem_wdata <= pick1_s ? wdata1 : wdata0;
                        mem_we    <= pick1_s ? we1    : we0;
                        mem_req   <= 1'b1;
                        cnt_r     <= {CW{1'b0}};
                    end
                end
                ST_BUSY: begin
                    if (mem_ready) begin
                        rdata   <= mem_rdata;
                        err     <= 1'b0;
                        mem_req <= 1'b0;
                        done0   <= mux_s;
                        done1   <= ~mux_s;
                    end else if (timeout_s) begin
                        rdata   <= {DW{1'b0}};
                        err     <= 1'b1;
                        mem_req <= 1'b0;
                        done0   <= mux_s;
                        done1   <= ~mux_s;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_DONE: begin
                    cnt_r <= {CW{1'b0}};
                end
                default: begin
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
